interrupt_arbiter: RTL and testbench

Selects the highest-priority enabled interrupt from the machine/supervisor pending bits and presents one frozen, stable request to the global control unit. It sits between the CSR unit (mip/mie/mideleg/mstatus/privilege) and the gc unit's `interrupt_pending`/`interrupt_take` handshake. It guarantees the cause cannot change between request and take. It also produces the WFI wake-up indication.

---
 rtl/csr_types.sv | 33 +++
 rtl/interrupt_arbiter_if.sv | 26 ++
 rtl/interrupt_priority_encoder.sv | 26 ++
 rtl/interrupt_arbiter.sv | 86 ++++++++
 tb/tb_interrupt_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_types.sv
// Interrupt cause codes, mip/mie bit positions, privilege encodings and the fixed
// interrupt priority order shared by the interrupt arbiter blocks.
package csr_types;

    typedef logic [4:0] exception_code_t;

    localparam exception_code_t CauseSsi = 5'd1;
    localparam exception_code_t CauseMsi = 5'd3;
    localparam exception_code_t CauseSti = 5'd5;
    localparam exception_code_t CauseMti = 5'd7;
    localparam exception_code_t CauseSei = 5'd9;
    localparam exception_code_t CauseMei = 5'd11;

    localparam int unsigned IrqSsi = 1;
    localparam int unsigned IrqMsi = 3;
    localparam int unsigned IrqSti = 5;
    localparam int unsigned IrqMti = 7;
    localparam int unsigned IrqSei = 9;
    localparam int unsigned IrqMei = 11;

    // Interrupt bits that exist at all, and the subset that exists without S-mode.
    localparam logic [11:0] IrqMaskAll = 12'hAAA;
    localparam logic [11:0] IrqMaskM   = 12'h888;

    localparam logic [1:0] PrivU = 2'd0;
    localparam logic [1:0] PrivS = 2'd1;
    localparam logic [1:0] PrivM = 2'd3;

    // Entry 0 is the highest priority; bit position equals cause code.
    localparam int unsigned NumIrq = 6;
    localparam logic [3:0] IrqPriority [NumIrq] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Handshake bundle between the CSR unit / gc unit (master) and the interrupt arbiter (slave).
interface interrupt_arbiter_if;
    import csr_types::*;

    logic [11:0]     mip;
    logic [11:0]     mie;
    logic [11:0]     mideleg;
    logic            mstatus_mie;
    logic            mstatus_sie;
    logic [1:0]      privilege;
    logic            interrupt_take;
    logic            interrupt_pending;
    exception_code_t interrupt_cause;
    logic            interrupt_to_s;
    logic            wfi_wake;

    modport master (
        output mip, mie, mideleg, mstatus_mie, mstatus_sie, privilege, interrupt_take,
        input  interrupt_pending, interrupt_cause, interrupt_to_s, wfi_wake
    );

    modport slave (
        input  mip, mie, mideleg, mstatus_mie, mstatus_sie, privilege, interrupt_take,
        output interrupt_pending, interrupt_cause, interrupt_to_s, wfi_wake
    );
endinterface

// File: rtl/interrupt_priority_encoder.sv
// Combinational fixed-priority pick over a fully qualified 12-bit eligible mask.
module interrupt_priority_encoder
    import csr_types::*;
(
    input  logic [11:0]     eligible,
    input  logic [11:0]     s_level,
    output exception_code_t cause,
    output logic            target_s,
    output logic            valid
);

    // Walk from lowest to highest priority so the highest eligible bit is written last.
    always_comb begin
        cause    = '0;
        target_s = 1'b0;
        valid    = 1'b0;
        for (int i = NumIrq - 1; i >= 0; i--) begin
            if (eligible[IrqPriority[i]]) begin
                cause    = {1'b0, IrqPriority[i]};
                target_s = s_level[IrqPriority[i]];
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Qualifies pending interrupts and hands one frozen request at a time to the gc unit.
module interrupt_arbiter
    import csr_types::*;
#(
    parameter bit INCLUDE_S_MODE = 1'b0
) (
    input logic                clk,
    input logic                rst,
    interrupt_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StArmed, StCooldown} state_e;

    state_e          state_q;
    logic [11:0]     irq_mask;
    logic [11:0]     s_level;
    logic [11:0]     local_en;
    logic [11:0]     enabled;
    logic            m_global_en;
    logic            s_global_en;
    exception_code_t enc_cause;
    logic            enc_to_s;
    logic            enc_valid;

    assign irq_mask = INCLUDE_S_MODE ? IrqMaskAll : IrqMaskM;
    assign s_level  = INCLUDE_S_MODE ? (bus.mideleg & IrqMaskAll) : 12'h000;
    assign local_en = bus.mip & bus.mie & irq_mask;

    assign m_global_en = (bus.privilege != PrivM) || bus.mstatus_mie;
    // Privilege 2 is reserved; it is above S, so S-level bits stay masked there.
    assign s_global_en = (bus.privilege == PrivU) ||
                         ((bus.privilege == PrivS) && bus.mstatus_sie);

    assign enabled = local_en & ((~s_level & {12{m_global_en}}) |
                                 (s_level & {12{s_global_en}}));

    interrupt_priority_encoder u_encoder (
        .eligible (enabled),
        .s_level  (s_level),
        .cause    (enc_cause),
        .target_s (enc_to_s),
        .valid    (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q               <= StIdle;
            bus.interrupt_pending <= 1'b0;
            bus.interrupt_cause   <= '0;
            bus.interrupt_to_s    <= 1'b0;
            bus.wfi_wake          <= 1'b0;
        end else begin
            bus.wfi_wake <= |local_en;
            unique case (state_q)
                StIdle: begin
                    if (enc_valid) begin
                        state_q               <= StArmed;
                        bus.interrupt_pending <= 1'b1;
                        bus.interrupt_cause   <= enc_cause;
                        bus.interrupt_to_s    <= enc_to_s;
                    end
                end
                StArmed: begin
                    if (bus.interrupt_take) begin
                        state_q               <= StCooldown;
                        bus.interrupt_pending <= 1'b0;
                    end else if (!enabled[bus.interrupt_cause[3:0]]) begin
                        state_q               <= StIdle;
                        bus.interrupt_pending <= 1'b0;
                    end
                end
                StCooldown: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q               <= StIdle;
                    bus.interrupt_pending <= 1'b0;
                end
            endcase
        end
    end

    take_only_when_armed: assert property (@(posedge clk) disable iff (!rst)
        bus.interrupt_take |-> (state_q == StArmed));

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter with S-mode support enabled.
module tb_interrupt_arbiter;
    import csr_types::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    interrupt_arbiter_if bus ();

    interrupt_arbiter #(
        .INCLUDE_S_MODE (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        bus.mip = '0;
        bus.mie = '0;
        bus.mideleg = '0;
        bus.interrupt_take = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.mip = 12'h888;
        bus.mie = 12'h888;
        bus.mideleg = '0;
        bus.mstatus_mie = 1'b1;
        bus.mstatus_sie = 1'b0;
        bus.privilege = PrivM;
        bus.interrupt_take = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.interrupt_pending, bus.interrupt_cause, bus.interrupt_to_s, bus.wfi_wake} !== 8'h00)
            $display("FAIL reset_outputs got p=%0b c=%0d s=%0b w=%0b want all 0",
                     bus.interrupt_pending, bus.interrupt_cause, bus.interrupt_to_s, bus.wfi_wake);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd11)
            $display("FAIL reset_release got p=%0b c=%0d want p=1 c=11",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        total++;
        if (bus.wfi_wake !== 1'b1)
            $display("FAIL reset_wfi got %0b want 1", bus.wfi_wake);
        else passed++;
        bus.interrupt_take = 1'b1;
        tick();
        bus.interrupt_take = 1'b0;
        quiesce();
    endtask

    task automatic test_priority();
        bus.mip = 12'h088;
        bus.mie = 12'h088;
        bus.privilege = PrivM;
        bus.mstatus_mie = 1'b1;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd3)
            $display("FAIL prio_msi got p=%0b c=%0d want p=1 c=3",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        bus.interrupt_take = 1'b1;
        tick();
        bus.interrupt_take = 1'b0;
        bus.mip = 12'h080;
        total++;
        if (bus.interrupt_pending !== 1'b0)
            $display("FAIL prio_after_take got %0b want 0", bus.interrupt_pending);
        else passed++;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b0)
            $display("FAIL prio_cooldown got %0b want 0", bus.interrupt_pending);
        else passed++;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd7)
            $display("FAIL prio_mti got p=%0b c=%0d want p=1 c=7",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        quiesce();
    endtask

    task automatic test_freeze_abort();
        bus.mip = 12'h080;
        bus.mie = 12'h880;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd7)
            $display("FAIL freeze_arm got p=%0b c=%0d want p=1 c=7",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        bus.mip = 12'h880;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd7)
            $display("FAIL freeze_hold got p=%0b c=%0d want p=1 c=7",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        bus.mip = 12'h800;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b0 || bus.interrupt_cause !== 5'd7)
            $display("FAIL abort got p=%0b c=%0d want p=0 c=7",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd11)
            $display("FAIL rearm_mei got p=%0b c=%0d want p=1 c=11",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        quiesce();
    endtask

    task automatic test_delegation();
        bus.mideleg = 12'h200;
        bus.mip = 12'h200;
        bus.mie = 12'h200;
        bus.mstatus_mie = 1'b1;
        bus.mstatus_sie = 1'b0;
        bus.privilege = PrivS;
        tick();
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b0)
            $display("FAIL deleg_s_sie0 got %0b want 0", bus.interrupt_pending);
        else passed++;
        bus.privilege = PrivU;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd9 ||
            bus.interrupt_to_s !== 1'b1)
            $display("FAIL deleg_u got p=%0b c=%0d s=%0b want p=1 c=9 s=1",
                     bus.interrupt_pending, bus.interrupt_cause, bus.interrupt_to_s);
        else passed++;
        bus.privilege = PrivM;
        tick();
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b0 || bus.interrupt_to_s !== 1'b1)
            $display("FAIL deleg_m got p=%0b s=%0b want p=0 s=1 (held)",
                     bus.interrupt_pending, bus.interrupt_to_s);
        else passed++;
        // Same pending SEI without delegation is an M-level trap.
        bus.mideleg = 12'h000;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_to_s !== 1'b0)
            $display("FAIL undeleg_sei got p=%0b s=%0b want p=1 s=0",
                     bus.interrupt_pending, bus.interrupt_to_s);
        else passed++;
        quiesce();
    endtask

    task automatic test_take_abort_same_cycle();
        bus.privilege = PrivM;
        bus.mstatus_mie = 1'b1;
        bus.mip = 12'h080;
        bus.mie = 12'h080;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1)
            $display("FAIL ta_arm got %0b want 1", bus.interrupt_pending);
        else passed++;
        bus.interrupt_take = 1'b1;
        bus.mip = 12'h000;
        tick();
        bus.interrupt_take = 1'b0;
        bus.mip = 12'h080;
        total++;
        if (bus.interrupt_pending !== 1'b0)
            $display("FAIL ta_cycle1 got %0b want 0", bus.interrupt_pending);
        else passed++;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b0)
            $display("FAIL ta_cycle2 got %0b want 0", bus.interrupt_pending);
        else passed++;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_cause !== 5'd7)
            $display("FAIL ta_rearm got p=%0b c=%0d want p=1 c=7",
                     bus.interrupt_pending, bus.interrupt_cause);
        else passed++;
        quiesce();
    endtask

    task automatic test_wfi();
        bus.mstatus_mie = 1'b0;
        bus.privilege = PrivM;
        bus.mip = 12'h080;
        bus.mie = 12'h080;
        tick();
        total++;
        if (bus.wfi_wake !== 1'b1 || bus.interrupt_pending !== 1'b0)
            $display("FAIL wfi_wake got w=%0b p=%0b want w=1 p=0",
                     bus.wfi_wake, bus.interrupt_pending);
        else passed++;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b0)
            $display("FAIL wfi_no_req got %0b want 0", bus.interrupt_pending);
        else passed++;
        // Lower privilege makes the M-level bit globally enabled regardless of mstatus.mie.
        bus.privilege = PrivU;
        tick();
        total++;
        if (bus.interrupt_pending !== 1'b1 || bus.interrupt_to_s !== 1'b0)
            $display("FAIL u_mode_mti got p=%0b s=%0b want p=1 s=0",
                     bus.interrupt_pending, bus.interrupt_to_s);
        else passed++;
        bus.mie = 12'h000;
        tick();
        total++;
        if (bus.wfi_wake !== 1'b0 || bus.interrupt_pending !== 1'b0)
            $display("FAIL wfi_clear got w=%0b p=%0b want w=0 p=0",
                     bus.wfi_wake, bus.interrupt_pending);
        else passed++;
        quiesce();
    endtask

    task automatic test_reset_mid_armed();
        bus.privilege = PrivM;
        bus.mstatus_mie = 1'b1;
        bus.mip = 12'h800;
        bus.mie = 12'h800;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({bus.interrupt_pending, bus.interrupt_cause, bus.interrupt_to_s, bus.wfi_wake} !== 8'h00)
            $display("FAIL reset_mid_armed got p=%0b c=%0d s=%0b w=%0b want all 0",
                     bus.interrupt_pending, bus.interrupt_cause, bus.interrupt_to_s, bus.wfi_wake);
        else passed++;
        rst = 1'b1;
        quiesce();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_priority();
        test_freeze_abort();
        test_delegation();
        test_take_abort_same_cycle();
        test_wfi();
        test_reset_mid_armed();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
